sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
// Input conditioning stage for the board slide switches, directly upstream of the LSU.
// - Synchronises the raw asynchronous switch pins into i_clk.
// - Debounces each bit independently.
// - Drives the stable value into the LSU switch input (i_io_sw).
// - Emits one-cycle rise/fall pulses per bit for future interrupt/event logic.
// PARAMETERS
// WIDTH         32     number of switch bits conditioned (unused upper pins tied 0)
// TICK_DIV      50000  i_clk cycles per sample tick (1 ms at 50 MHz); legal range >= 1
// STABLE_TICKS  10     consecutive ticks a new level must persist before it is accepted; legal range >= 1
// PORTS
// i_clk      in   1      system clock
// i_reset    in   1      asynchronous reset, active-low
// i_sw_raw   in   WIDTH  raw switch pins, asynchronous to i_clk
// o_io_sw    out  WIDTH  debounced switch value, connects to LSU i_io_sw
// o_sw_rise  out  WIDTH  one-cycle pulse per bit when o_io_sw bit goes 0->1
// o_sw_fall  out  WIDTH  one-cycle pulse per bit when o_io_sw bit goes 1->0
// o_tick     out  1      one-cycle sample-tick strobe (debug/visibility)
// BEHAVIOUR
// Reset (i_reset=0, asynchronous):
// - Synchroniser flops, prescaler, all per-bit counters, o_io_sw, o_sw_rise, o_sw_fall and o_tick clear to 0.
// - Reset asserted mid-count discards all partial progress.
// - After release, debouncing restarts from o_io_sw=0.
// Synchroniser:
// - Two flops per bit: sync1 <= i_sw_raw, then sync2 <= sync1.
// - Only sync2 is used downstream.
// Prescaler:
// - Counter runs 0..TICK_DIV-1 and wraps to 0.
// - o_tick=1 in the cycle where count==TICK_DIV-1.
// - TICK_DIV=1 gives o_tick=1 every cycle.
// - Width is $clog2(TICK_DIV) with a minimum of 1 bit.
// Per-bit counter:
// - cnt[i] is $clog2(STABLE_TICKS+1) bits wide and saturates, never wraps.
// - sync2[i]==o_io_sw[i] in any cycle: cnt[i]<=0, tick or no tick. Any bounce back resets progress.
// - sync2[i]!=o_io_sw[i], o_tick=1, cnt[i]<STABLE_TICKS-1: cnt[i]<=cnt[i]+1.
// - sync2[i]!=o_io_sw[i], o_tick=1, cnt[i]==STABLE_TICKS-1: o_io_sw[i]<=sync2[i] and cnt[i]<=0, on the same edge.
// - sync2[i]!=o_io_sw[i], o_tick=0: cnt[i] holds.
// Edge pulses:
// - o_sw_rise[i] / o_sw_fall[i] are registered and high for exactly the one cycle following the edge that updates o_io_sw[i].
// - Each pulse is coincident with the new o_io_sw value.
// - They are 0 in every other cycle.
// - Multiple bits may update and pulse in the same cycle.
// Latency:
// - A clean level change is accepted 2 cycles (sync) plus STABLE_TICKS ticks after it is sampled.
// - Worst case is 2 + STABLE_TICKS*TICK_DIV cycles.
// - A change shorter than STABLE_TICKS consecutive ticks is never propagated.
// Misc:
// - o_io_sw is glitch-free (direct flop outputs).
// - The LSU may sample it in any cycle.
// - No combinational path from i_sw_raw to any output.
// TESTING
// (TICK_DIV=1, STABLE_TICKS=4 unless stated)
// T1 reset:
//    - Hold i_reset=0 with i_sw_raw=32'hFFFF_FFFF -> all outputs 0.
//    - Release -> o_io_sw=32'hFFFF_FFFF after exactly 6 edges.
//    - o_sw_rise=32'hFFFF_FFFF for exactly that one cycle.
// T2 clean edge:
//    - Step i_sw_raw[0] 0->1 before edge E1 -> o_io_sw[0] becomes 1 after edge E6.
//    - o_sw_rise[0]=1 for one cycle only.
//    - o_sw_fall stays 0.
// T3 bounce:
//    - Toggle i_sw_raw[3] every 2 cycles for 40 cycles, then hold 0 -> o_io_sw[3] stays 0.
//    - No rise/fall pulse on bit 3.
// T4 fall and multi-bit:
//    - From o_io_sw=32'h0000_00F0, set raw=32'h0000_000F -> both change on the same edge.
//    - o_sw_fall=32'h0000_00F0 and o_sw_rise=32'h0000_000F on the same single cycle.
// T5 reset mid-operation:
//    - Assert i_reset=0 asynchronously with cnt[0]=2 and sync2[0]=1 -> outputs clear immediately, without waiting for i_clk.
//    - After release with raw held 1, the full 6-edge latency is required again.
// T6 prescaler (TICK_DIV=5, STABLE_TICKS=3):
//    - o_tick=1 once every 5 cycles.
//    - A raw change held for 2 ticks then removed produces no update.
//    - Held >=3 ticks -> update on the 3rd tick edge after sync2 changes.

Source files
------------

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser, shared sample-tick prescaler,
// per-bit saturating stability counters, and registered rise/fall event pulses.
module sw_debounce #(
  parameter int WIDTH        = 32,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_io_sw,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic             o_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [PW-1:0]    pre_cnt;
  logic [PW-1:0]    pre_next;
  logic [CW-1:0]    cnt [WIDTH];

  // NOTE: every path assigns pre_next, so this stays pure combinational logic
  // with no inferred latch.
  always_comb begin
    pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_sw_raw;
      sync2 <= sync1;
    end
  end

  // o_tick is registered so it is high exactly while pre_cnt sits at its last value.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pre_cnt <= '0;
      o_tick  <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      o_tick  <= (pre_next == PRE_LAST);
    end
  end

  // NOTE: the per-bit counters are ordinary flops, not a memory, and all of them
  // are reset so a reset mid-count throws away any partial progress.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_io_sw   <= '0;
      o_sw_rise <= '0;
      o_sw_fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      o_sw_rise <= '0;
      o_sw_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == o_io_sw[i]) begin
          cnt[i] <= '0;
        end else if (o_tick) begin
          if (cnt[i] >= CNT_LAST) begin
            o_io_sw[i]   <= sync2[i];
            o_sw_rise[i] <= sync2[i];
            o_sw_fall[i] <= ~sync2[i];
            cnt[i]       <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: scripted stimulus pushes expected switch events into
// per-instance queues; monitors pop and compare whenever a pulse appears.
module tb_sw_debounce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] raw_a = '0, raw_b = '0;
  logic [31:0] io_a, rise_a, fall_a, io_b, rise_b, fall_b;
  logic        tick_a, tick_b;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  typedef struct {
    int          at;
    logic [31:0] io;
    logic [31:0] rise;
    logic [31:0] fall;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sw_debounce #(.WIDTH(32), .TICK_DIV(1), .STABLE_TICKS(4)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_sw_raw(raw_a),
    .o_io_sw(io_a), .o_sw_rise(rise_a), .o_sw_fall(fall_a), .o_tick(tick_a)
  );

  sw_debounce #(.WIDTH(32), .TICK_DIV(5), .STABLE_TICKS(3)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_sw_raw(raw_b),
    .o_io_sw(io_b), .o_sw_rise(rise_b), .o_sw_fall(fall_b), .o_tick(tick_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input int dt, input logic [31:0] io, input logic [31:0] rise,
                        input logic [31:0] fall);
    ev_t e;
    e.at = cyc + dt; e.io = io; e.rise = rise; e.fall = fall;
    qa.push_back(e);
  endtask

  task automatic push_b(input int dt, input logic [31:0] io, input logic [31:0] rise,
                        input logic [31:0] fall);
    ev_t e;
    e.at = cyc + dt; e.io = io; e.rise = rise; e.fall = fall;
    qb.push_back(e);
  endtask

  // Steps until dut_b shows a tick (at most 20 cycles); returns cycles stepped.
  task automatic wait_tick_b(output int d);
    d = 0;
    do begin
      step(1);
      d++;
    end while (!tick_b && d < 20);
  endtask

  always @(negedge clk) begin
    if (rst_n && ((rise_a | fall_a) != '0)) begin
      if (qa.size() == 0) begin
        check("a_unexpected_pulse", rise_a | fall_a, 32'h0);
      end else begin
        ev_t e;
        e = qa.pop_front();
        check("a_cycle", cyc, e.at);
        check("a_io", io_a, e.io);
        check("a_rise", rise_a, e.rise);
        check("a_fall", fall_a, e.fall);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ((rise_b | fall_b) != '0)) begin
      if (qb.size() == 0) begin
        check("b_unexpected_pulse", rise_b | fall_b, 32'h0);
      end else begin
        ev_t e;
        e = qb.pop_front();
        check("b_cycle", cyc, e.at);
        check("b_io", io_b, e.io);
        check("b_rise", rise_b, e.rise);
        check("b_fall", fall_b, e.fall);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d;

    // T1: reset with all switches high, then the 6-edge acceptance.
    raw_a = 32'hFFFF_FFFF;
    step(3);
    check("t1_rst_io", io_a, 32'h0);
    check("t1_rst_rise", rise_a, 32'h0);
    check("t1_rst_fall", fall_a, 32'h0);
    check("t1_rst_tick", 32'(tick_a), 32'h0);
    check("t1_rst_tick_b", 32'(tick_b), 32'h0);
    rst_n = 1'b1;
    push_a(6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    step(5);
    check("t1_not_early", io_a, 32'h0);
    step(5);
    check("t1_io", io_a, 32'hFFFF_FFFF);

    raw_a = 32'h0;
    push_a(6, 32'h0, 32'h0, 32'hFFFF_FFFF);
    step(10);

    // T2: clean rising edge on bit 0.
    raw_a = 32'h1;
    push_a(6, 32'h1, 32'h1, 32'h0);
    step(10);
    check("t2_io", io_a, 32'h1);

    // T3: bit 3 bounces with a 2-cycle half period, never long enough.
    for (int i = 0; i < 10; i++) begin
      raw_a[3] = 1'b1;
      step(2);
      raw_a[3] = 1'b0;
      step(2);
    end
    step(10);
    check("t3_io", io_a, 32'h1);

    // T4: mixed rise/fall, then a simultaneous multi-bit swap.
    raw_a = 32'h0000_00F0;
    push_a(6, 32'h0000_00F0, 32'h0000_00F0, 32'h0000_0001);
    step(10);
    raw_a = 32'h0000_000F;
    push_a(6, 32'h0000_000F, 32'h0000_000F, 32'h0000_00F0);
    step(10);
    check("t4_io", io_a, 32'h0000_000F);

    // T5: asynchronous reset while bit 0 is two ticks into a change.
    raw_a = 32'h30;
    push_a(6, 32'h30, 32'h30, 32'h0F);
    step(10);
    raw_a = 32'h31;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_io", io_a, 32'h0);
    check("t5_async_tick", 32'(tick_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push_a(6, 32'h31, 32'h31, 32'h0);
    step(5);
    check("t5_not_early", io_a, 32'h0);
    step(5);
    check("t5_io", io_a, 32'h31);
    check("a_queue_drained", qa.size(), 32'h0);

    // T6: prescaler period and tick-counted latency on dut_b.
    wait_tick_b(d);
    check("t6_tick_found", 32'(tick_b), 32'h1);
    for (int k = 0; k < 3; k++) begin
      wait_tick_b(d);
      check("t6_tick_period", d, 32'd5);
    end
    raw_b = 32'h1;
    step(11);
    raw_b = 32'h0;
    step(20);
    check("t6_short_io", io_b, 32'h0);
    wait_tick_b(d);
    raw_b = 32'h5;
    push_b(16, 32'h5, 32'h5, 32'h0);
    step(20);
    check("t6_io", io_b, 32'h5);
    check("b_queue_drained", qb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
